// File: rtl/instr_fetch_pkg.sv
// Shared CPU definitions: fetch FSM encoding, NOP instruction, PC step.
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // MIPS NOP (sll $0,$0,0) is the all-zero word
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Byte distance between consecutive instruction words
    localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: PC, valid flag and an instruction hold register.
// The program memory keeps reading while decode is stalled, so the word that
// was on imem_q at the start of a stall is captured and replayed until the
// stall ends.
module if_id_reg
    import instr_fetch_pkg::*;
#(
    parameter int BIT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  flush,
    input  logic                  stall,
    input  logic [ADDR_WIDTH-1:0] pc_in,
    input  logic [BIT_WIDTH-1:0]  imem_q,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic [BIT_WIDTH-1:0]  instr_out,
    output logic                  valid_out
);

    logic [BIT_WIDTH-1:0] hold_reg;
    logic                 hold_active;
    logic [BIT_WIDTH-1:0] instr_cur;

    // Current instruction: replayed copy during a stall, live memory otherwise
    assign instr_cur = hold_active ? hold_reg : imem_q;
    assign instr_out = valid_out ? instr_cur : BIT_WIDTH'(NOP_INSTR);

    // Flush beats load beats stall capture; capture only once per stall
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_out      <= '0;
            valid_out   <= 1'b0;
            hold_reg    <= '0;
            hold_active <= 1'b0;
        end else if (flush) begin
            valid_out   <= 1'b0;
            hold_reg    <= '0;
            hold_active <= 1'b0;
        end else if (load) begin
            pc_out      <= pc_in;
            valid_out   <= 1'b1;
            hold_active <= 1'b0;
        end else if (stall && valid_out && !hold_active) begin
            hold_reg    <= instr_cur;
            hold_active <= 1'b1;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetch PC, IDLE/RUN/HALT sequencing, redirect
// handling and accepted-instruction counter, feeding an IF/ID register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | RESET_PC on imem_addr, nothing valid yet
//   RUN     | fetching; advance, hold on stall, or take a redirect
//   HALT    | halted (halt_req or misaligned target); only reset leaves
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                    BIT_WIDTH       = 32,
    parameter int                    ADDR_WIDTH      = 32,
    parameter int                    IMEM_ADDR_WIDTH = 6,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc,
    input  logic                       halt_req,
    output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
    input  logic [BIT_WIDTH-1:0]       imem_q,
    output logic [BIT_WIDTH-1:0]       instr_out,
    output logic [ADDR_WIDTH-1:0]      pc_out,
    output logic [ADDR_WIDTH-1:0]      pc_plus4_out,
    output logic                       valid_out,
    output logic                       misalign,
    output logic [31:0]                fetch_count
);

    fetch_state_t          state;
    logic [ADDR_WIDTH-1:0] pc_f;
    logic [ADDR_WIDTH-1:0] pc_f_next_seq;
    logic                  redirect_bad;
    logic                  reg_load;
    logic                  reg_flush;
    logic                  unused_pc_bits;

    assign imem_addr      = pc_f[IMEM_ADDR_WIDTH+1:2];
    assign unused_pc_bits = ^{pc_f[ADDR_WIDTH-1:IMEM_ADDR_WIDTH+2], pc_f[1:0]};
    assign pc_f_next_seq  = pc_f + ADDR_WIDTH'(PC_INC);
    assign pc_plus4_out   = pc_out + ADDR_WIDTH'(PC_INC);
    assign redirect_bad   = (redirect_pc[1:0] != 2'b00);

    // IF/ID register control: IDLE issues the first fetch; redirect or halt
    // flushes the slot; a stall simply holds it
    always_comb begin
        reg_load  = 1'b0;
        reg_flush = 1'b0;
        case (state)
            ST_IDLE: reg_load = 1'b1;
            ST_RUN: begin
                if (redirect || halt_req) begin
                    reg_flush = 1'b1;
                end else if (!stall) begin
                    reg_load = 1'b1;
                end
            end
            default: reg_flush = 1'b1;
        endcase
    end

    // Fetch FSM, fetch PC, sticky misalign flag and accepted-instruction count
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= ST_IDLE;
            pc_f        <= RESET_PC;
            misalign    <= 1'b0;
            fetch_count <= '0;
        end else begin
            if (valid_out && !stall && !redirect) begin
                fetch_count <= fetch_count + 32'd1;
            end
            case (state)
                ST_IDLE: begin
                    state <= ST_RUN;
                    pc_f  <= pc_f_next_seq;
                end
                ST_RUN: begin
                    if (redirect) begin
                        if (redirect_bad) begin
                            misalign <= 1'b1;
                            state    <= ST_HALT;
                        end else begin
                            pc_f <= redirect_pc;
                            if (halt_req) begin
                                state <= ST_HALT;
                            end
                        end
                    end else if (halt_req) begin
                        state <= ST_HALT;
                    end else if (!stall) begin
                        pc_f <= pc_f_next_seq;
                    end
                end
                default: state <= ST_HALT;
            endcase
        end
    end

    if_id_reg #(
        .BIT_WIDTH (BIT_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (reg_load),
        .flush    (reg_flush),
        .stall    (stall),
        .pc_in    (pc_f),
        .imem_q   (imem_q),
        .pc_out   (pc_out),
        .instr_out(instr_out),
        .valid_out(valid_out)
    );

endmodule
